// File: rtl/x_delay_line_pkg.sv
// Shared types and helpers for the delay-line TDC: FSM state encoding and the
// thermometer leading-ones / bubble evaluator used by the encoder.
package x_delay_line_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRE,
    ST_CAPT,
    ST_ENC,
    ST_SETTLE,
    ST_DONE
  } tdc_state_t;

  // Widest chain the helper can evaluate; callers zero-pad to this width.
  localparam int TDC_MAX_W = 256;

  typedef struct packed {
    logic [15:0] cnt;
    logic        bubble;
  } lead_ones_t;

  // Counts consecutive ones from bit 0 and flags any one above the first zero.
  function automatic lead_ones_t lead_ones(input logic [TDC_MAX_W-1:0] vec, input int width);
    lead_ones_t res;
    logic       seen_zero;
    res       = '0;
    seen_zero = 1'b0;
    for (int i = 0; i < TDC_MAX_W; i++) begin
      if (i < width) begin
        if (seen_zero) begin
          res.bubble = res.bubble | vec[i];
        end else if (vec[i]) begin
          res.cnt = res.cnt + 16'd1;
        end else begin
          seen_zero = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/x_delay_line_cell.sv
// One delay element: a buffer stage forwarding the edge plus a capture flop
// sampling the stage input every clock.
module x_delay_line_cell (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_dl,
  output logic o_dl,
  output logic o_dat
);

  logic dat_q;

  assign o_dl  = i_dl;
  assign o_dat = dat_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dat_q <= 1'b0;
    end else begin
      dat_q <= i_dl;
    end
  end

endmodule

// File: rtl/x_delay_line_enc.sv
// Combinational normaliser and thermometer encoder: flips the snapshot so that
// "edge passed" reads as 1 for either launch polarity, then counts it.
module x_delay_line_enc
  import x_delay_line_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0] raw_i,
  input  logic             pol_i,
  output logic [DEPTH-1:0] n_o,
  output logic [CNT_W-1:0] count_o,
  output logic             bubble_o,
  output logic             sat_o
);

  logic [TDC_MAX_W-1:0] vec;
  lead_ones_t           res;

  assign n_o = raw_i ^ {DEPTH{~pol_i}};

  always_comb begin
    vec            = '0;
    vec[DEPTH-1:0] = n_o;
    res            = lead_ones(vec, DEPTH);
    count_o        = res.cnt[CNT_W-1:0];
    bubble_o       = res.bubble;
    sat_o          = (res.cnt == 16'(DEPTH));
  end

endmodule

// File: rtl/x_delay_line_tdc.sv
// FSM-driven delay-line TDC: launch, capture, encode, optionally average 2^AVG_LOG2 shots.
// Result strobe 4 cycles after start per shot; no backpressure, start is ignored while busy.
module x_delay_line_tdc
  import x_delay_line_pkg::*;
#(
  parameter  int DEPTH    = 32,
  parameter  int AVG_LOG2 = 0,
  localparam int CNT_W    = $clog2(DEPTH + 1),
  localparam int SUM_W    = CNT_W + AVG_LOG2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_cont,
  output logic             o_busy,
  output logic             o_valid,
  output logic [SUM_W-1:0] o_sum,
  output logic [DEPTH-1:0] o_data,
  output logic             o_bubble,
  output logic             o_sat
);

  localparam logic [AVG_LOG2:0] SHOT_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

  tdc_state_t        state_q;
  logic              launch_q;
  logic [DEPTH:0]    dl;
  logic [DEPTH-1:0]  cell_dat;
  logic [DEPTH-1:0]  raw;
  logic [DEPTH-1:0]  n;
  logic [CNT_W-1:0]  count;
  logic              bubble;
  logic              sat;
  logic              unused_load_dl;
  logic              unused_load_dat;

  logic [SUM_W-1:0]  acc_q, acc_d;
  logic              bub_q, bub_d;
  logic              sat_q, sat_d;
  logic [AVG_LOG2:0] shot_q;
  logic              busy_q, valid_q, o_bub_q, o_sat_q;
  logic [SUM_W-1:0]  sum_q;
  logic [DEPTH-1:0]  data_q;

  assign dl[0] = launch_q;

  // The extra top cell only loads the last measured stage so it sees a realistic fan-out.
  for (genvar g = 0; g <= DEPTH; g++) begin : g_cell
    if (g < DEPTH) begin : g_meas
      x_delay_line_cell u_cell (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_dl  (dl[g]),
        .o_dl  (dl[g+1]),
        .o_dat (cell_dat[g])
      );
    end else begin : g_load
      x_delay_line_cell u_cell (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_dl  (dl[g]),
        .o_dl  (unused_load_dl),
        .o_dat (unused_load_dat)
      );
    end
  end

  assign raw = cell_dat;

  x_delay_line_enc #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_enc (
    .raw_i    (raw),
    .pol_i    (launch_q),
    .n_o      (n),
    .count_o  (count),
    .bubble_o (bubble),
    .sat_o    (sat)
  );

  always_comb begin
    acc_d = acc_q + SUM_W'(count);
    bub_d = bub_q | bubble;
    sat_d = sat_q | sat;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      launch_q <= 1'b0;
      acc_q    <= '0;
      bub_q    <= 1'b0;
      sat_q    <= 1'b0;
      shot_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      sum_q    <= '0;
      data_q   <= '0;
      o_bub_q  <= 1'b0;
      o_sat_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_q <= ST_FIRE;
            busy_q  <= 1'b1;
            acc_q   <= '0;
            shot_q  <= '0;
            bub_q   <= 1'b0;
            sat_q   <= 1'b0;
          end
        end
        ST_FIRE: begin
          launch_q <= ~launch_q;
          state_q  <= ST_CAPT;
        end
        ST_CAPT: state_q <= ST_ENC;
        ST_ENC: begin
          data_q  <= n;
          acc_q   <= acc_d;
          sum_q   <= acc_d;
          bub_q   <= bub_d;
          o_bub_q <= bub_d;
          sat_q   <= sat_d;
          o_sat_q <= sat_d;
          shot_q  <= shot_q + 1'b1;
          if (shot_q == SHOT_LAST) begin
            state_q <= ST_DONE;
            valid_q <= 1'b1;
          end else begin
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: state_q <= ST_FIRE;
        ST_DONE: begin
          if (i_cont) begin
            state_q <= ST_FIRE;
            acc_q   <= '0;
            shot_q  <= '0;
            bub_q   <= 1'b0;
            sat_q   <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy   = busy_q;
  assign o_valid  = valid_q;
  assign o_sum    = sum_q;
  assign o_data   = data_q;
  assign o_bubble = o_bub_q;
  assign o_sat    = o_sat_q;

endmodule

// File: tb/tb_x_delay_line_tdc.sv
// Directed bench for x_delay_line_tdc: a single-shot and a 4-shot averaging instance,
// with per-shot propagation imposed by forcing the captured chain snapshot.
module tb_x_delay_line_tdc;

  logic       clk;
  logic       i_rst;
  logic       d0_start, d0_cont, d2_start, d2_cont;
  logic       d0_busy, d0_valid, d0_bub, d0_sat;
  logic       d2_busy, d2_valid, d2_bub, d2_sat;
  logic [3:0] d0_sum;
  logic [5:0] d2_sum;
  logic [7:0] d0_data, d2_data;

  typedef struct {
    logic [5:0] sum;
    logic [7:0] data;
    logic       bub;
    logic       sat;
  } exp_t;

  exp_t exp0_q[$];
  exp_t exp2_q[$];
  int   vectors = 0;
  int   fails   = 0;
  logic pol0, pol2;
  logic [7:0] raw0, raw2;

  x_delay_line_tdc #(.DEPTH(8), .AVG_LOG2(0)) u_dut0 (
    .i_clk(clk), .i_rst(i_rst), .i_start(d0_start), .i_cont(d0_cont),
    .o_busy(d0_busy), .o_valid(d0_valid), .o_sum(d0_sum), .o_data(d0_data),
    .o_bubble(d0_bub), .o_sat(d0_sat)
  );

  x_delay_line_tdc #(.DEPTH(8), .AVG_LOG2(2)) u_dut2 (
    .i_clk(clk), .i_rst(i_rst), .i_start(d2_start), .i_cont(d2_cont),
    .o_busy(d2_busy), .o_valid(d2_valid), .o_sum(d2_sum), .o_data(d2_data),
    .o_bubble(d2_bub), .o_sat(d2_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next shot launches the opposite polarity; build the raw snapshot that
  // normalises to npat under that polarity.
  task automatic set_raw0(input logic [7:0] npat);
    pol0 = ~pol0;
    raw0 = pol0 ? npat : ~npat;
    force u_dut0.raw = raw0;
  endtask

  task automatic set_raw2(input logic [7:0] npat);
    pol2 = ~pol2;
    raw2 = pol2 ? npat : ~npat;
    force u_dut2.raw = raw2;
  endtask

  task automatic push0(input logic [5:0] s, input logic [7:0] d, input logic b, input logic t);
    exp_t e;
    e.sum = s; e.data = d; e.bub = b; e.sat = t;
    exp0_q.push_back(e);
  endtask

  task automatic push2(input logic [5:0] s, input logic [7:0] d, input logic b, input logic t);
    exp_t e;
    e.sum = s; e.data = d; e.bub = b; e.sat = t;
    exp2_q.push_back(e);
  endtask

  // Advance one clock and pop/compare the scoreboard on every result strobe.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (d0_valid) begin
      if (exp0_q.size() == 0) begin
        chk("d0 spurious valid", 32'(d0_valid), 32'd0);
      end else begin
        e = exp0_q.pop_front();
        chk("d0 sum", 32'(d0_sum), 32'(e.sum));
        chk("d0 data", 32'(d0_data), 32'(e.data));
        chk("d0 bubble", 32'(d0_bub), 32'(e.bub));
        chk("d0 sat", 32'(d0_sat), 32'(e.sat));
      end
    end
    if (d2_valid) begin
      if (exp2_q.size() == 0) begin
        chk("d2 spurious valid", 32'(d2_valid), 32'd0);
      end else begin
        e = exp2_q.pop_front();
        chk("d2 sum", 32'(d2_sum), 32'(e.sum));
        chk("d2 data", 32'(d2_data), 32'(e.data));
        chk("d2 bubble", 32'(d2_bub), 32'(e.bub));
        chk("d2 sat", 32'(d2_sat), 32'(e.sat));
      end
    end
  endtask

  initial begin
    int   toggles;
    logic prev_launch;
    i_rst = 1'b1;
    d0_start = 1'b0; d0_cont = 1'b0; d2_start = 1'b0; d2_cont = 1'b0;
    pol0 = 1'b0; pol2 = 1'b0;
    raw0 = '0; raw2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 32'(d0_busy), 32'd0);
    chk("rst valid", 32'(d0_valid), 32'd0);
    chk("rst sum", 32'(d0_sum), 32'd0);
    chk("rst data", 32'(d0_data), 32'd0);
    chk("rst bubble", 32'(d0_bub), 32'd0);
    chk("rst sat", 32'(d0_sat), 32'd0);
    chk("rst d2 busy", 32'(d2_busy), 32'd0);
    i_rst = 1'b0;
    step();

    // Edge reaches 5 cells: strobe exactly at cycle 4.
    set_raw0(8'h1F);
    push0(6'd5, 8'h1F, 1'b0, 1'b0);
    d0_start = 1'b1;
    step();
    d0_start = 1'b0;
    chk("c1 busy", 32'(d0_busy), 32'd1);
    chk("c1 valid", 32'(d0_valid), 32'd0);
    step(); chk("c2 valid", 32'(d0_valid), 32'd0);
    step(); chk("c3 valid", 32'(d0_valid), 32'd0);
    step(); chk("c4 valid", 32'(d0_valid), 32'd1);
    step();
    chk("c5 valid", 32'(d0_valid), 32'd0);
    chk("c5 busy", 32'(d0_busy), 32'd0);

    // Bubble above the first zero.
    set_raw0(8'h27);
    push0(6'd3, 8'h27, 1'b1, 1'b0);
    d0_start = 1'b1;
    step();
    d0_start = 1'b0;
    repeat (3) step();
    chk("bubble valid", 32'(d0_valid), 32'd1);
    step();

    // Reset in the middle of FIRE discards the shot.
    set_raw0(8'h1F);
    d0_start = 1'b1;
    step();
    d0_start = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    chk("midrst busy", 32'(d0_busy), 32'd0);
    chk("midrst valid", 32'(d0_valid), 32'd0);
    chk("midrst sum", 32'(d0_sum), 32'd0);
    chk("midrst data", 32'(d0_data), 32'd0);
    chk("midrst bubble", 32'(d0_bub), 32'd0);
    chk("midrst launch", 32'(u_dut0.launch_q), 32'd0);
    @(posedge clk);
    #1 i_rst = 1'b0;
    pol0 = 1'b0; pol2 = 1'b0;
    repeat (8) step();
    chk("post rst idle", 32'(d0_busy), 32'd0);

    // Real cells: the edge covers the whole chain, once per launch polarity.
    release u_dut0.raw;
    for (int k = 0; k < 2; k++) begin
      pol0 = ~pol0;
      push0(6'd8, 8'hFF, 1'b0, 1'b1);
      d0_start = 1'b1;
      step();
      d0_start = 1'b0;
      repeat (3) step();
      chk("full valid", 32'(d0_valid), 32'd1);
      step();
    end

    // Four-shot average with a bubble in the third shot only.
    set_raw2(8'h07);
    push2(6'd16, 8'h1F, 1'b1, 1'b0);
    toggles = 0;
    prev_launch = u_dut2.launch_q;
    d2_start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      d2_start = 1'b0;
      if (u_dut2.launch_q !== prev_launch) toggles++;
      prev_launch = u_dut2.launch_q;
      chk($sformatf("avg valid c%0d", c), 32'(d2_valid), 32'(c == 16));
      if (c == 4)  set_raw2(8'h0F);
      if (c == 8)  set_raw2(8'h2F);
      if (c == 12) set_raw2(8'h1F);
    end
    chk("avg toggles", 32'(toggles), 32'd4);
    step();
    chk("avg idle", 32'(d2_busy), 32'd0);

    // Continuous mode, start pulse while busy, then drop cont.
    d0_cont = 1'b1;
    set_raw0(8'h3F);
    for (int k = 0; k < 3; k++) push0(6'd6, 8'h3F, 1'b0, 1'b0);
    d0_start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 1) d0_start = 1'b0;
      if (c == 4 || c == 8) set_raw0(8'h3F);
      if (c == 6) d0_start = 1'b1;
      if (c == 7) d0_start = 1'b0;
      if (c == 9) d0_cont = 1'b0;
      chk($sformatf("cont valid c%0d", c), 32'(d0_valid), 32'(c == 4 || c == 8 || c == 12));
      if (c >= 13) chk($sformatf("cont busy c%0d", c), 32'(d0_busy), 32'd0);
    end

    chk("d0 pending", 32'(exp0_q.size()), 32'd0);
    chk("d2 pending", 32'(exp2_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
